pc_sequencer: RTL and testbench

- Owns the architectural program-counter register and sequences fetch: sequential step, relative branch, absolute jump, stall, halt/resume and optional single-level interrupt entry/return.
- Sits between the control unit (branch/jump/halt decisions) and instruction memory (out_pc drives the fetch address).
- Word-addressed PC; every computed PC is registered, with one update per in_clk rising edge.

---
 rtl/pcseq_pkg.sv | 14 +
 rtl/pcseq_next_pc.sv | 32 +++
 rtl/pc_sequencer.sv | 144 ++++++++++++++
 tb/tb_pc_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcseq_pkg.sv
// Shared types and default parameter values for the program-counter sequencer.
package pcseq_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ISR  = 2'd1,
        ST_HALT = 2'd2
    } pcseq_state_e;

    localparam int          PCSEQ_PC_W       = 32;
    localparam logic [31:0] PCSEQ_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] PCSEQ_IRQ_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/pcseq_next_pc.sv
// Combinational next-PC datapath: sequential step, relative branch and the
// jump/branch/step selection (jump beats branch beats step).
module pcseq_next_pc
    import pcseq_pkg::*;
#(
    parameter int PC_W = PCSEQ_PC_W
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] branch_offset,
    input  logic [PC_W-1:0] jump_target,
    input  logic            branch_taken,
    input  logic            jump,
    output logic [PC_W-1:0] seq_pc,
    output logic [PC_W-1:0] sel_pc
);

    logic [PC_W-1:0] branch_pc;

    // Both sums wrap modulo 2^PC_W; the offset is two's complement.
    assign seq_pc    = pc + PC_W'(1);
    assign branch_pc = pc + branch_offset;

    always_comb begin
        sel_pc = seq_pc;
        if (jump) begin
            sel_pc = jump_target;
        end else if (branch_taken) begin
            sel_pc = branch_pc;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and fetch sequencing. Interrupt entry/return is
// built only when PCSEQ_IRQ_EN is defined.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_RUN  | normal fetch
//   ST_ISR  | in interrupt handler, further irqs masked
//   ST_HALT | PC frozen until in_resume
module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter int              PC_W       = PCSEQ_PC_W,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(PCSEQ_RESET_PC),
    parameter logic [PC_W-1:0] IRQ_VECTOR = PC_W'(PCSEQ_IRQ_VECTOR)
) (
    input  logic            in_clk,
    input  logic            in_rst_n,
    input  logic            in_stall,
    input  logic            in_branch_taken,
    input  logic [PC_W-1:0] in_branch_offset,
    input  logic            in_jump,
    input  logic [PC_W-1:0] in_jump_target,
    input  logic            in_halt,
    input  logic            in_resume,
    input  logic            in_irq,
    input  logic            in_eret,
    output logic [PC_W-1:0] out_pc,
    output logic            out_pc_valid,
    output logic            out_halted,
    output logic            out_in_isr,
    output logic [PC_W-1:0] out_epc
);

    pcseq_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] seq_pc, sel_pc;
    logic            valid_q;

    pcseq_next_pc #(.PC_W(PC_W)) u_next_pc (
        .pc            (pc_q),
        .branch_offset (in_branch_offset),
        .jump_target   (in_jump_target),
        .branch_taken  (in_branch_taken),
        .jump          (in_jump),
        .seq_pc        (seq_pc),
        .sel_pc        (sel_pc)
    );

`ifdef PCSEQ_IRQ_EN
    logic [PC_W-1:0] epc_q, epc_d;
    logic            halt_from_q, halt_from_d;   // 1: halted from ISR
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PCSEQ_IRQ_EN
        epc_d       = epc_q;
        halt_from_d = halt_from_q;
`endif
        if (!in_stall) begin
            case (state_q)
                ST_RUN: begin
                    if (in_halt) begin
                        state_d = ST_HALT;
                        pc_d    = seq_pc;
`ifdef PCSEQ_IRQ_EN
                        halt_from_d = 1'b0;
                    end else if (in_irq) begin
                        // Return address is whatever RUN would have fetched next.
                        epc_d   = sel_pc;
                        pc_d    = IRQ_VECTOR;
                        state_d = ST_ISR;
`endif
                    end else begin
                        pc_d = sel_pc;
                    end
                end
`ifdef PCSEQ_IRQ_EN
                ST_ISR: begin
                    if (in_halt) begin
                        state_d     = ST_HALT;
                        pc_d        = seq_pc;
                        halt_from_d = 1'b1;
                    end else if (in_eret) begin
                        pc_d    = epc_q;
                        state_d = ST_RUN;
                    end else begin
                        pc_d = sel_pc;
                    end
                end
`endif
                ST_HALT: begin
                    if (in_resume) begin
`ifdef PCSEQ_IRQ_EN
                        state_d = halt_from_q ? ST_ISR : ST_RUN;
`else
                        state_d = ST_RUN;
`endif
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= 1'b1;
        end
    end

`ifdef PCSEQ_IRQ_EN
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            epc_q       <= '0;
            halt_from_q <= 1'b0;
        end else begin
            epc_q       <= epc_d;
            halt_from_q <= halt_from_d;
        end
    end

    assign out_in_isr = (state_q == ST_ISR);
    assign out_epc    = epc_q;
`else
    // Interface stays fixed; irq inputs and vector have no function here.
    logic unused_irq;
    assign unused_irq = ^{in_irq, in_eret, IRQ_VECTOR};
    assign out_in_isr = 1'b0;
    assign out_epc    = '0;
`endif

    assign out_pc       = pc_q;
    assign out_halted   = (state_q == ST_HALT);
    assign out_pc_valid = valid_q && (state_q != ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; the irq scenarios run when PCSEQ_IRQ_EN is defined.
module tb_pc_sequencer;

    logic        in_clk = 1'b0;
    logic        in_rst_n = 1'b0;
    logic        in_stall = 1'b0;
    logic        in_branch_taken = 1'b0;
    logic [31:0] in_branch_offset = '0;
    logic        in_jump = 1'b0;
    logic [31:0] in_jump_target = '0;
    logic        in_halt = 1'b0;
    logic        in_resume = 1'b0;
    logic        in_irq = 1'b0;
    logic        in_eret = 1'b0;
    logic [31:0] out_pc;
    logic        out_pc_valid;
    logic        out_halted;
    logic        out_in_isr;
    logic [31:0] out_epc;

    pc_sequencer dut (
        .in_clk           (in_clk),
        .in_rst_n         (in_rst_n),
        .in_stall         (in_stall),
        .in_branch_taken  (in_branch_taken),
        .in_branch_offset (in_branch_offset),
        .in_jump          (in_jump),
        .in_jump_target   (in_jump_target),
        .in_halt          (in_halt),
        .in_resume        (in_resume),
        .in_irq           (in_irq),
        .in_eret          (in_eret),
        .out_pc           (out_pc),
        .out_pc_valid     (out_pc_valid),
        .out_halted       (out_halted),
        .out_in_isr       (out_in_isr),
        .out_epc          (out_epc)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic        stall;
        logic        br;
        logic [31:0] off;
        logic        jump;
        logic [31:0] tgt;
        logic        halt;
        logic        resume;
        logic        irq;
        logic        eret;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic        halted;
        logic        isr;
        logic [31:0] pc;
        logic [31:0] epc;
    } obs_t;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    int    n_tests = 0;
    int    n_fail = 0;

    function automatic stim_t mk_s(input logic stall, input logic br, input logic [31:0] off,
                                   input logic jump, input logic [31:0] tgt, input logic halt,
                                   input logic resume, input logic irq, input logic eret);
        stim_t s;
        s.stall = stall; s.br = br; s.off = off; s.jump = jump; s.tgt = tgt;
        s.halt = halt; s.resume = resume; s.irq = irq; s.eret = eret;
        return s;
    endfunction

    function automatic stim_t idle_s();
        return mk_s(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    endfunction

    function automatic obs_t mk_o(input logic valid, input logic halted, input logic isr,
                                  input logic [31:0] pc, input logic [31:0] epc);
        obs_t o;
        o.valid = valid; o.halted = halted; o.isr = isr; o.pc = pc; o.epc = epc;
        return o;
    endfunction

    function automatic obs_t observe();
        return mk_o(out_pc_valid, out_halted, out_in_isr, out_pc, out_epc);
    endfunction

    task automatic drive(input stim_t s);
        in_stall = s.stall; in_branch_taken = s.br; in_branch_offset = s.off;
        in_jump = s.jump; in_jump_target = s.tgt; in_halt = s.halt;
        in_resume = s.resume; in_irq = s.irq; in_eret = s.eret;
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // Queue one cycle of stimulus with the outputs expected after its edge.
    task automatic add(input stim_t s, input obs_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        obs_t e, o;
        tick(); tick();
        exp_q.push_back(mk_o(0, 0, 0, 32'h0, 32'h0));
        e = exp_q.pop_front(); o = observe(); n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_held: got pc=%h v=%b h=%b isr=%b epc=%h, want pc=%h v=%b h=%b isr=%b epc=%h",
                     o.pc, o.valid, o.halted, o.isr, o.epc, e.pc, e.valid, e.halted, e.isr, e.epc);
        end
        in_rst_n = 1'b1;
        exp_q.push_back(mk_o(0, 0, 0, 32'h0, 32'h0));
        e = exp_q.pop_front(); o = observe(); n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_release: got pc=%h v=%b, want pc=%h v=%b", o.pc, o.valid, e.pc, e.valid);
        end
        for (int i = 1; i <= 4; i++) add(idle_s(), mk_o(1, 0, 0, 32'(i), 32'h0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front()); tick();
            e = exp_q.pop_front(); o = observe(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_count[%0d]: got pc=%h v=%b h=%b isr=%b epc=%h, want pc=%h v=%b h=%b isr=%b epc=%h",
                         i, o.pc, o.valid, o.halted, o.isr, o.epc, e.pc, e.valid, e.halted, e.isr, e.epc);
            end
        end
    endtask

    task automatic test_branch();
        obs_t e, o;
        add(mk_s(0, 0, 32'h0, 1, 32'd10, 0, 0, 0, 0), mk_o(1, 0, 0, 32'd10, 32'h0));
        add(mk_s(0, 1, -32'sd3, 0, 32'h0, 0, 0, 0, 0), mk_o(1, 0, 0, 32'd7, 32'h0));
        add(mk_s(0, 1, 32'd5, 1, 32'h40, 0, 0, 0, 0), mk_o(1, 0, 0, 32'h40, 32'h0));
        add(mk_s(0, 1, 32'd0, 0, 32'h0, 0, 0, 0, 0), mk_o(1, 0, 0, 32'h40, 32'h0));
        add(mk_s(0, 1, 32'd6, 0, 32'h0, 0, 0, 0, 0), mk_o(1, 0, 0, 32'h46, 32'h0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front()); tick();
            e = exp_q.pop_front(); o = observe(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL branch[%0d]: got pc=%h v=%b h=%b isr=%b epc=%h, want pc=%h v=%b h=%b isr=%b epc=%h",
                         i, o.pc, o.valid, o.halted, o.isr, o.epc, e.pc, e.valid, e.halted, e.isr, e.epc);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t e, o;
        add(mk_s(0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0), mk_o(1, 0, 0, 32'hFFFF_FFFF, 32'h0));
        add(idle_s(), mk_o(1, 0, 0, 32'h0, 32'h0));
        add(idle_s(), mk_o(1, 0, 0, 32'h1, 32'h0));
        add(mk_s(0, 1, 32'hFFFF_FFFE, 0, 32'h0, 0, 0, 0, 0), mk_o(1, 0, 0, 32'hFFFF_FFFF, 32'h0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front()); tick();
            e = exp_q.pop_front(); o = observe(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got pc=%h v=%b h=%b isr=%b epc=%h, want pc=%h v=%b h=%b isr=%b epc=%h",
                         i, o.pc, o.valid, o.halted, o.isr, o.epc, e.pc, e.valid, e.halted, e.isr, e.epc);
            end
        end
    endtask

    task automatic test_stall();
        obs_t e, o;
        add(mk_s(0, 0, 32'h0, 1, 32'd5, 0, 0, 0, 0), mk_o(1, 0, 0, 32'd5, 32'h0));
        for (int k = 0; k < 3; k++)
            add(mk_s(1, 0, 32'h0, 1, 32'h77, 0, 0, 0, 0), mk_o(1, 0, 0, 32'd5, 32'h0));
        add(mk_s(1, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0), mk_o(1, 0, 0, 32'd5, 32'h0));
        add(mk_s(0, 0, 32'h0, 1, 32'h77, 0, 0, 0, 0), mk_o(1, 0, 0, 32'h77, 32'h0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front()); tick();
            e = exp_q.pop_front(); o = observe(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stall[%0d]: got pc=%h v=%b h=%b isr=%b epc=%h, want pc=%h v=%b h=%b isr=%b epc=%h",
                         i, o.pc, o.valid, o.halted, o.isr, o.epc, e.pc, e.valid, e.halted, e.isr, e.epc);
            end
        end
    endtask

    task automatic test_halt();
        obs_t e, o;
        add(mk_s(0, 0, 32'h0, 1, 32'd20, 0, 0, 0, 0), mk_o(1, 0, 0, 32'd20, 32'h0));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0), mk_o(0, 1, 0, 32'd21, 32'h0));
        for (int k = 0; k < 4; k++)
            add(mk_s(0, 1, 32'd3, 1, 32'h99, 1, 0, 0, 0), mk_o(0, 1, 0, 32'd21, 32'h0));
        add(mk_s(1, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0), mk_o(0, 1, 0, 32'd21, 32'h0));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0), mk_o(1, 0, 0, 32'd21, 32'h0));
        add(idle_s(), mk_o(1, 0, 0, 32'd22, 32'h0));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0), mk_o(1, 0, 0, 32'd23, 32'h0));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1), mk_o(1, 0, 0, 32'd24, 32'h0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front()); tick();
            e = exp_q.pop_front(); o = observe(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL halt[%0d]: got pc=%h v=%b h=%b isr=%b epc=%h, want pc=%h v=%b h=%b isr=%b epc=%h",
                         i, o.pc, o.valid, o.halted, o.isr, o.epc, e.pc, e.valid, e.halted, e.isr, e.epc);
            end
        end
    endtask

`ifdef PCSEQ_IRQ_EN
    task automatic test_irq();
        obs_t e, o;
        add(mk_s(0, 0, 32'h0, 1, 32'd30, 0, 0, 0, 0), mk_o(1, 0, 0, 32'd30, 32'h0));
        add(mk_s(0, 1, 32'd8, 0, 32'h0, 0, 0, 1, 0), mk_o(1, 0, 1, 32'h100, 32'd38));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0), mk_o(1, 0, 1, 32'h101, 32'd38));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1), mk_o(1, 0, 0, 32'd38, 32'd38));
        // halt beats irq, irq is taken once RUN resumes
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 1, 0, 1, 0), mk_o(0, 1, 0, 32'd39, 32'd38));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 0, 1, 1, 0), mk_o(1, 0, 0, 32'd39, 32'd38));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0), mk_o(1, 0, 1, 32'h100, 32'd40));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0), mk_o(0, 1, 0, 32'h101, 32'd40));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0), mk_o(1, 0, 1, 32'h101, 32'd40));
        add(idle_s(), mk_o(1, 0, 1, 32'h102, 32'd40));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front()); tick();
            e = exp_q.pop_front(); o = observe(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL irq[%0d]: got pc=%h v=%b h=%b isr=%b epc=%h, want pc=%h v=%b h=%b isr=%b epc=%h",
                         i, o.pc, o.valid, o.halted, o.isr, o.epc, e.pc, e.valid, e.halted, e.isr, e.epc);
            end
        end
    endtask
`else
    task automatic test_irq_ignored();
        obs_t e, o;
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0), mk_o(1, 0, 0, 32'd25, 32'h0));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 1), mk_o(1, 0, 0, 32'd26, 32'h0));
        add(mk_s(0, 0, 32'h0, 0, 32'h0, 1, 0, 1, 0), mk_o(0, 1, 0, 32'd27, 32'h0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front()); tick();
            e = exp_q.pop_front(); o = observe(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL irq_ignored[%0d]: got pc=%h v=%b h=%b isr=%b epc=%h, want pc=%h v=%b h=%b isr=%b epc=%h",
                         i, o.pc, o.valid, o.halted, o.isr, o.epc, e.pc, e.valid, e.halted, e.isr, e.epc);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        obs_t e, o;
        drive(idle_s());
        #2;
        in_rst_n = 1'b0;
        #1;
        exp_q.push_back(mk_o(0, 0, 0, 32'h0, 32'h0));
        e = exp_q.pop_front(); o = observe(); n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid: got pc=%h v=%b h=%b isr=%b epc=%h, want pc=%h v=%b h=%b isr=%b epc=%h",
                     o.pc, o.valid, o.halted, o.isr, o.epc, e.pc, e.valid, e.halted, e.isr, e.epc);
        end
        tick();
        in_rst_n = 1'b1;
        tick();
        exp_q.push_back(mk_o(1, 0, 0, 32'h1, 32'h0));
        e = exp_q.pop_front(); o = observe(); n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got pc=%h v=%b h=%b isr=%b epc=%h, want pc=%h v=%b h=%b isr=%b epc=%h",
                     o.pc, o.valid, o.halted, o.isr, o.epc, e.pc, e.valid, e.halted, e.isr, e.epc);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_wrap();
        test_stall();
        test_halt();
`ifdef PCSEQ_IRQ_EN
        test_irq();
`else
        test_irq_ignored();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
